fma_sched: RTL and testbench
============================

FMA_SCHED -- requirements
Module: fma_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one FP16 FMA pipeline; fixed at 4 for this revision.
REQ-002 Parameter LAT, default 2, clock edges from operand issue to a valid fpu_exd.
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-004 ACLK  input  1  clock; all state changes on its rising edge.
REQ-005 RSTN  input  1  asynchronous active-low reset.
REQ-006 en  input  1  issue enable; 0 blocks new grants while in-flight ops still drain.
REQ-007 req_valid  input  4  requester i has an FMA operation ready.
REQ-008 req_ready  output  4  one-hot grant; the op is accepted when req_valid[i] and req_ready[i] are both 1.
REQ-009 req_ex1, req_ex2, req_ex3  input  64 each  FP16 operands; requester i uses bits [16i+15:16i].
REQ-010 rsp_valid  output  4  result pending for requester i.
REQ-011 rsp_ready  input  4  requester i consumes its result.
REQ-012 rsp_data  output  64  FP16 result; requester i uses bits [16i+15:16i].
REQ-013 fpu_op  output  2  pipeline opcode; constant 2'h0 (FMA).
REQ-014 fpu_ex1, fpu_ex2, fpu_ex3  output  16 each  operands to the pipeline's first stage.
REQ-015 fpu_exd  input  16  normalized result from the pipeline's final stage.
REQ-016 busy  output  1  high when any op is in flight or any result is unconsumed.

Function
REQ-017 Requester i SHALL be eligible when req_valid[i]=1, en=1 and pend[i]=0.
  - pend[i] is set on grant and cleared on the rsp_valid/rsp_ready handshake.
REQ-018 Arbitration SHALL be round-robin.
  - Search starts at (last_grant+1) mod 4.
  - Pointer updates only on a grant.
  - At most one grant per cycle.
REQ-019 req_ready SHALL be combinational from req_valid, en, pend and the pointer.
  - It does not depend on any other handshake input.
REQ-020 While a grant is active, fpu_ex1/2/3 SHALL carry the granted requester's operands unchanged; otherwise they are 16'h0000.
REQ-021 A 2-stage tag pipe (v1,id1)->(v2,id2) SHALL track ops.
  - Grant in cycle N sets v1 at the end of cycle N.
  - v2 is set at the end of cycle N+1.
  - At the end of cycle N+2 with v2=1, rsp_data[id2] <= fpu_exd and rsp_valid[id2] <= 1.
REQ-022 The issue-to-rsp_valid latency SHALL be exactly 3 cycles (LAT+1). The pipeline has no stall, so the tag pipe never stalls.
REQ-023 rsp_valid[i] and rsp_data[i] SHALL hold until rsp_ready[i]=1.
  - They are cleared at the end of the handshake cycle.
  - pend[i] also clears then.
  - The earliest regrant to i is the next cycle.
REQ-024 Because each requester has one outstanding op, result-slot overflow SHALL be impossible. No result is ever dropped or overwritten.
REQ-025 Sustained throughput SHALL be 1 issue/cycle across requesters. A single requester is limited to 1 op per 4 cycles when rsp_ready is held high.
REQ-026 en deasserted mid-stream SHALL stop grants only; ops in v1/v2 still complete and deliver responses.
REQ-027 Two results SHALL never complete for the same requester in one cycle. Completion and handshake on different requesters in the same cycle SHALL both take effect.
REQ-028 busy SHALL equal |pend.

Reset
REQ-029 While RSTN=0, the following SHALL be 0 immediately, independent of ACLK: rsp_valid, rsp_data, pend, v1, v2, id1, id2 and busy.
  - The round-robin pointer resets to 3, so requester 0 has first priority.
REQ-030 Reset mid-operation SHALL discard all in-flight ops and pending results. fpu_exd is ignored until a new grant propagates.
REQ-031 req_ready and fpu_ex* SHALL be 0 while RSTN=0.

Verification
REQ-032 Requester 0 only sends ex1=ex2=ex3=3C00 in cycle N, with rsp_ready=1 -> req_ready[0]=1 in N; rsp_valid[0]=1 and rsp_data[15:0]=4000 in N+3.
REQ-033 All 4 requesters hold req_valid with operands 4000,4000,4000 -> grants go 0,1,2,3 on consecutive cycles; each rsp_data lane is 4600, and lanes arrive on consecutive cycles.
REQ-034 Requester 2 holds rsp_ready=0 for 10 cycles after its result -> rsp_valid[2] and its data stay stable, requester 2 gets no regrant, and others keep issuing.
REQ-035 en=0 one cycle after two grants -> both results still arrive 3 cycles after their issue, no further grants occur, and busy falls after the final handshake.
REQ-036 RSTN pulsed low while ops are in v1 and v2 -> all outputs are 0 immediately, no rsp_valid appears afterward, and the next grant goes to requester 0.
REQ-037 Operands 0000,0000,0000 -> rsp_data lane = 0000; the bench also checks fpu_op stays 0 throughout.

Source files
------------

// File: rtl/fma_sched.sv
// fma_sched: round-robin issue of NREQ requesters into one FP16 FMA pipeline,
// tracking each op with a tag pipe and holding its result until consumed.
module fma_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic                 ACLK,
    input  logic                 RSTN,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_ex1,
    input  logic [16*NREQ-1:0]   req_ex2,
    input  logic [16*NREQ-1:0]   req_ex3,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [16*NREQ-1:0]   rsp_data,
    output logic [1:0]           fpu_op,
    output logic [15:0]          fpu_ex1,
    output logic [15:0]          fpu_ex2,
    output logic [15:0]          fpu_ex3,
    input  logic [15:0]          fpu_exd,
    output logic                 busy
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0] pend, elig, hs, done;
    logic [IW-1:0]   ptr, gid;
    logic            any;
    logic [LAT-1:0]  v;
    logic [IW-1:0]   id [LAT];

    // Reset gates eligibility so no grant or operand leaks out while RSTN is low.
    assign elig = req_valid & ~pend & {NREQ{en & RSTN}};

    always_comb begin
        any = 1'b0;
        gid = '0;
        for (int k = 1; k <= NREQ; k++) begin
            logic [IW-1:0] idx;
            idx = IW'((int'(ptr) + k) % NREQ);
            if (!any && elig[idx]) begin
                any = 1'b1;
                gid = idx;
            end
        end
    end

    assign req_ready = any ? (NREQ'(1) << gid) : '0;
    assign fpu_ex1   = any ? req_ex1[16*gid +: 16] : 16'h0000;
    assign fpu_ex2   = any ? req_ex2[16*gid +: 16] : 16'h0000;
    assign fpu_ex3   = any ? req_ex3[16*gid +: 16] : 16'h0000;
    assign fpu_op    = 2'h0;
    assign busy      = |pend;
    assign hs        = rsp_valid & rsp_ready;
    assign done      = v[LAT-1] ? (NREQ'(1) << id[LAT-1]) : '0;

    always_ff @(posedge ACLK or negedge RSTN) begin
        if (!RSTN) begin
            pend      <= '0;
            ptr       <= IW'(NREQ - 1);
            v         <= '0;
            for (int k = 0; k < LAT; k++) id[k] <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            v     <= LAT'({v, any});
            id[0] <= gid;
            for (int k = 1; k < LAT; k++) id[k] <= id[k-1];
            ptr       <= any ? gid : ptr;
            pend      <= (pend | req_ready) & ~hs;
            rsp_valid <= (rsp_valid & ~hs) | done;
            // A lane cannot complete and hand off in the same cycle: one op outstanding per requester.
            for (int i = 0; i < NREQ; i++) begin
                if (done[i])
                    rsp_data[16*i +: 16] <= fpu_exd;
                else if (hs[i])
                    rsp_data[16*i +: 16] <= 16'h0000;
            end
        end
    end
endmodule

// File: tb/tb_fma_sched.sv
// tb_fma_sched: directed stimulus with a per-requester scoreboard; a monitor
// checks result data, issue-to-result latency and hold behaviour.
module tb_fma_sched;
    logic        ACLK = 1'b0, RSTN = 1'b1, en = 1'b0;
    logic [3:0]  req_valid = '0, rsp_ready = '0;
    logic [63:0] req_ex1 = '0, req_ex2 = '0, req_ex3 = '0;
    logic [3:0]  req_ready, rsp_valid;
    logic [63:0] rsp_data;
    logic [1:0]  fpu_op;
    logic [15:0] fpu_ex1, fpu_ex2, fpu_ex3, fpu_exd;
    logic        busy;

    fma_sched dut (
        .ACLK(ACLK), .RSTN(RSTN), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ex1(req_ex1), .req_ex2(req_ex2), .req_ex3(req_ex3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .fpu_op(fpu_op), .fpu_ex1(fpu_ex1), .fpu_ex2(fpu_ex2), .fpu_ex3(fpu_ex3),
        .fpu_exd(fpu_exd), .busy(busy)
    );

    always #5 ACLK = ~ACLK;

    int nvec = 0, nmis = 0, cyc = 0;
    always @(posedge ACLK) cyc++;

    // Hand-evaluated a*b+c for the operand triples the bench uses.
    function automatic logic [15:0] fma16(input logic [15:0] a, b, c);
        case ({a, b, c})
            {16'h3C00, 16'h3C00, 16'h3C00}: return 16'h4000;
            {16'h4000, 16'h4000, 16'h4000}: return 16'h4600;
            {16'h3C00, 16'h4000, 16'h3C00}: return 16'h4200;
            48'h0:                          return 16'h0000;
            default:                        return 16'hDEAD;
        endcase
    endfunction

    // Two-stage pipeline stand-in; deliberately not reset.
    logic [15:0] s1 = 16'h1234, s2 = 16'h5678;
    always @(posedge ACLK) begin
        s1 <= fma16(fpu_ex1, fpu_ex2, fpu_ex3);
        s2 <= s1;
    end
    assign fpu_exd = s2;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        nvec++;
        if (a !== e) begin
            nmis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    typedef struct { logic [15:0] d; int c; } ent_t;
    ent_t        sb [4][$];
    ent_t        e_m;
    logic [15:0] exp_d [4];
    logic [3:0]  prv_v = '0, prv_r = '0;
    logic [63:0] prv_d = '0;

    always @(negedge ACLK) begin
        if (!RSTN) begin
            for (int i = 0; i < 4; i++) sb[i].delete();
            prv_v = '0;
        end else begin
            chk("fpu_op", 64'(fpu_op), 64'd0);
            chk("grant_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            for (int i = 0; i < 4; i++) begin
                if (prv_v[i] && !prv_r[i]) begin
                    chk("hold_valid", 64'(rsp_valid[i]), 64'd1);
                    chk("hold_data", 64'(rsp_data[16*i +: 16]), 64'(prv_d[16*i +: 16]));
                end
                if (rsp_valid[i] && !prv_v[i]) begin
                    if (sb[i].size() == 0) begin
                        nvec++;
                        nmis++;
                        $display("FAIL spurious_rsp lane %0d: got rsp_valid=1 data %h expected no result (cycle %0d)",
                                 i, rsp_data[16*i +: 16], cyc);
                    end else begin
                        e_m = sb[i].pop_front();
                        chk("rsp_data", 64'(rsp_data[16*i +: 16]), 64'(e_m.d));
                        chk("rsp_latency", 64'(cyc), 64'(e_m.c + 3));
                    end
                end
                if (req_valid[i] && req_ready[i]) begin
                    e_m.d = exp_d[i];
                    e_m.c = cyc;
                    sb[i].push_back(e_m);
                end
            end
            prv_v = rsp_valid;
            prv_r = rsp_ready;
            prv_d = rsp_data;
        end
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic smp();
        @(negedge ACLK);
    endtask

    task automatic set_ops(input logic [15:0] a, b, c, input logic [15:0] r);
        req_ex1 = {4{a}};
        req_ex2 = {4{b}};
        req_ex3 = {4{c}};
        for (int i = 0; i < 4; i++) exp_d[i] = r;
    endtask

    initial begin
        bit seen2;
        int others;
        for (int i = 0; i < 4; i++) exp_d[i] = 16'h0;
        // Reset state: outputs forced low even with requests pending
        req_valid = 4'hF; en = 1'b1; rsp_ready = 4'hF;
        #1 RSTN = 1'b0;
        #2;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_fpu_ex1", 64'(fpu_ex1), 64'd0);
        req_valid = '0;
        step(); step();
        RSTN = 1'b1;
        step();

        // All four requesters: grants 0,1,2,3 on consecutive cycles, results 4600
        set_ops(16'h4000, 16'h4000, 16'h4000, 16'h4600);
        req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("rr_order", 64'(req_ready), 64'(4'(1) << k));
            step();
        end
        req_valid = '0;
        repeat (6) step();
        chk("busy_idle_a", 64'(busy), 64'd0);

        // Single requester 0, 1+1*1 = 2
        set_ops(16'h3C00, 16'h3C00, 16'h3C00, 16'h4000);
        req_valid = 4'b0001;
        smp();
        chk("single_grant", 64'(req_ready), 64'd1);
        chk("fpu_ex1", 64'(fpu_ex1), 64'h3C00);
        chk("fpu_ex2", 64'(fpu_ex2), 64'h3C00);
        chk("fpu_ex3", 64'(fpu_ex3), 64'h3C00);
        step();
        req_valid = '0;
        smp();
        chk("busy_inflight", 64'(busy), 64'd1);
        step(); step();
        smp();
        chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("single_rsp_data", 64'(rsp_data[15:0]), 64'h4000);
        repeat (4) step();

        // Requester 2 stalls its result; others keep issuing
        set_ops(16'h3C00, 16'h3C00, 16'h3C00, 16'h4000);
        req_ex2[47:32] = 16'h4000;
        exp_d[2] = 16'h4200;
        rsp_ready = 4'b1011;
        req_valid = 4'hF;
        seen2 = 0;
        others = 0;
        for (int k = 0; k < 16; k++) begin
            smp();
            if (seen2) chk("no_regrant_2", 64'(req_ready[2]), 64'd0);
            if (req_ready[2]) seen2 = 1;
            if ((req_ready & 4'b1011) != 0) others++;
            step();
        end
        chk("granted_2", 64'(seen2), 64'd1);
        chk("others_issue", 64'(others >= 8), 64'd1);
        smp();
        chk("stall_valid_2", 64'(rsp_valid[2]), 64'd1);
        chk("stall_data_2", 64'(rsp_data[47:32]), 64'h4200);
        req_valid = '0;
        step();
        rsp_ready = 4'hF;
        repeat (6) step();
        chk("busy_idle_b", 64'(busy), 64'd0);

        // en dropped after two grants; zero operands give zero
        set_ops(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        req_valid = 4'hF;
        smp();
        chk("en_grant_a", 64'(req_ready != 0), 64'd1);
        step();
        smp();
        chk("en_grant_b", 64'(req_ready != 0), 64'd1);
        step();
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            smp();
            if (k == 0) chk("en_busy", 64'(busy), 64'd1);
            chk("en_block", 64'(req_ready), 64'd0);
            step();
        end
        chk("en_busy_fall", 64'(busy), 64'd0);
        chk("en_rsp_clear", 64'(rsp_valid), 64'd0);
        chk("en_data_clear", rsp_data, 64'd0);
        req_valid = '0;
        en = 1'b1;
        step();

        // Reset pulse with ops in both tag stages
        set_ops(16'h3C00, 16'h3C00, 16'h3C00, 16'h4000);
        req_valid = 4'hF;
        smp(); step();
        smp(); step();
        #1 RSTN = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_rsp_data", rsp_data, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_fpu_ex1", 64'(fpu_ex1), 64'd0);
        #4;
        req_valid = '0;
        RSTN = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            smp();
            chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        step();
        req_valid = 4'hF;
        smp();
        chk("post_rst_grant0", 64'(req_ready), 64'd1);
        step();
        req_valid = '0;
        repeat (8) step();

        for (int i = 0; i < 4; i++) chk("sb_drained", 64'(sb[i].size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
